// File: rtl/multicycle_control.sv
// Sequencing controller for the multi-cycle MIPS core: walks the shared datapath
// through fetch/decode/execute/memory/writeback, counts retirements, traps illegal encodings.
module multicycle_control #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [5:0]             opcode,
  input  logic [5:0]             alu_function,
  input  logic                   alu_zero,
  input  logic                   mem_ready,
  output logic                   mem_request,
  output logic                   mem_write,
  output logic                   iord,
  output logic                   ir_load,
  output logic                   pc_write,
  output logic [1:0]             pc_source,
  output logic                   alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic                   imm_zero_extend,
  output logic [3:0]             alu_control,
  output logic                   alu_out_load,
  output logic                   reg_write,
  output logic [1:0]             reg_dst,
  output logic [1:0]             mem_to_reg,
  output logic                   illegal_instruction,
  output logic [COUNT_WIDTH-1:0] retired_count
);

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, WB_ALU, MEM_ADDR,
    MEM_READ, WB_MEM, MEM_WRITE, BRANCH, JUMP, TRAP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F, OP_LW   = 6'h23, OP_SW   = 6'h2B;
  localparam logic [5:0] FN_SLL   = 6'h00, FN_SRL  = 6'h02, FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20, FN_SUB  = 6'h22, FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25, FN_SLT  = 6'h2A;
  localparam logic [3:0] ALU_ADD  = 4'd0,  ALU_SUB = 4'd1,  ALU_AND = 4'd2, ALU_OR = 4'd3;
  localparam logic [3:0] ALU_SLT  = 4'd4,  ALU_SLL = 4'd5,  ALU_SRL = 4'd6, ALU_LUI = 4'd7;

  state_t                 state_r;
  state_t                 next_state_s;
  logic                   retire_s;
  logic                   illegal_r;
  logic [COUNT_WIDTH-1:0] count_r;

  function automatic logic [3:0] r_alu_op(input logic [5:0] funct);
    case (funct)
      FN_SUB:  r_alu_op = ALU_SUB;
      FN_AND:  r_alu_op = ALU_AND;
      FN_OR:   r_alu_op = ALU_OR;
      FN_SLT:  r_alu_op = ALU_SLT;
      FN_SLL:  r_alu_op = ALU_SLL;
      FN_SRL:  r_alu_op = ALU_SRL;
      default: r_alu_op = ALU_ADD;
    endcase
  endfunction

  function automatic logic [3:0] i_alu_op(input logic [5:0] op);
    case (op)
      OP_SLTI: i_alu_op = ALU_SLT;
      OP_ANDI: i_alu_op = ALU_AND;
      OP_ORI:  i_alu_op = ALU_OR;
      OP_LUI:  i_alu_op = ALU_LUI;
      default: i_alu_op = ALU_ADD;
    endcase
  endfunction

  // Anything not explicitly recognised lands in TRAP.
  function automatic state_t decode_next(input logic [5:0] op, input logic [5:0] funct);
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLL, FN_SRL: decode_next = EXEC_R;
          FN_JR:   decode_next = JUMP;
          default: decode_next = TRAP;
        endcase
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: decode_next = EXEC_I;
      OP_LW, OP_SW:   decode_next = MEM_ADDR;
      OP_BEQ, OP_BNE: decode_next = BRANCH;
      OP_J, OP_JAL:   decode_next = JUMP;
      default:        decode_next = TRAP;
    endcase
  endfunction

  // Next-state and retirement decode.
  always_comb begin
    next_state_s = state_r;
    retire_s     = 1'b0;
    case (state_r)
      FETCH:     next_state_s = mem_ready ? DECODE : FETCH;
      DECODE:    next_state_s = decode_next(opcode, alu_function);
      EXEC_R:    next_state_s = WB_ALU;
      EXEC_I:    next_state_s = WB_ALU;
      WB_ALU:    begin next_state_s = FETCH; retire_s = 1'b1; end
      MEM_ADDR:  next_state_s = (opcode == OP_SW) ? MEM_WRITE : MEM_READ;
      MEM_READ:  next_state_s = mem_ready ? WB_MEM : MEM_READ;
      WB_MEM:    begin next_state_s = FETCH; retire_s = 1'b1; end
      MEM_WRITE: begin next_state_s = mem_ready ? FETCH : MEM_WRITE; retire_s = mem_ready; end
      BRANCH:    begin next_state_s = FETCH; retire_s = 1'b1; end
      JUMP:      begin next_state_s = FETCH; retire_s = 1'b1; end
      TRAP:      next_state_s = TRAP;
      default:   next_state_s = FETCH;
    endcase
  end

  // State, sticky trap flag and retirement counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= FETCH;
      illegal_r <= 1'b0;
      count_r   <= '0;
    end else begin
      state_r   <= next_state_s;
      illegal_r <= illegal_r | (next_state_s == TRAP);
      count_r   <= retire_s ? count_r + COUNT_WIDTH'(1) : count_r;
    end
  end

  // Moore strobe decode; held low while reset is asserted so no access leaks out.
  always_comb begin
    mem_request     = 1'b0;
    mem_write       = 1'b0;
    iord            = 1'b0;
    ir_load         = 1'b0;
    pc_write        = 1'b0;
    pc_source       = 2'd0;
    alu_src_a       = 1'b0;
    alu_src_b       = 2'd0;
    imm_zero_extend = 1'b0;
    alu_control     = ALU_ADD;
    alu_out_load    = 1'b0;
    reg_write       = 1'b0;
    reg_dst         = 2'd0;
    mem_to_reg      = 2'd0;
    if (!reset_n) begin
      mem_request = 1'b0;
      mem_write   = 1'b0;
      iord        = 1'b0;
    end else begin
      case (state_r)
        FETCH: begin
          mem_request = 1'b1;
          alu_src_b   = 2'd1;
          ir_load     = mem_ready;
          pc_write    = mem_ready;
        end
        DECODE: begin
          alu_src_b    = 2'd3;
          alu_out_load = 1'b1;
        end
        EXEC_R: begin
          alu_src_a    = 1'b1;
          alu_control  = r_alu_op(alu_function);
          alu_out_load = 1'b1;
        end
        EXEC_I: begin
          alu_src_a       = 1'b1;
          alu_src_b       = 2'd2;
          alu_control     = i_alu_op(opcode);
          imm_zero_extend = (opcode == OP_ANDI) || (opcode == OP_ORI);
          alu_out_load    = 1'b1;
        end
        WB_ALU: begin
          reg_write = 1'b1;
          reg_dst   = (opcode == OP_RTYPE) ? 2'd1 : 2'd0;
        end
        MEM_ADDR: begin
          alu_src_a    = 1'b1;
          alu_src_b    = 2'd2;
          alu_out_load = 1'b1;
        end
        MEM_READ: begin
          mem_request = 1'b1;
          iord        = 1'b1;
        end
        WB_MEM: begin
          reg_write  = 1'b1;
          mem_to_reg = 2'd1;
        end
        MEM_WRITE: begin
          mem_request = 1'b1;
          mem_write   = 1'b1;
          iord        = 1'b1;
        end
        BRANCH: begin
          alu_src_a   = 1'b1;
          alu_control = ALU_SUB;
          pc_source   = 2'd1;
          pc_write    = (opcode == OP_BEQ) ? alu_zero : !alu_zero;
        end
        JUMP: begin
          pc_write  = 1'b1;
          pc_source = (opcode == OP_RTYPE) ? 2'd3 : 2'd2;
          if (opcode == OP_JAL) begin
            reg_write  = 1'b1;
            reg_dst    = 2'd2;
            mem_to_reg = 2'd2;
          end else begin
            reg_write  = 1'b0;
          end
        end
        TRAP:    pc_write = 1'b0;
        default: pc_write = 1'b0;
      endcase
    end
  end

  assign illegal_instruction = illegal_r;
  assign retired_count       = count_r;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Sequencing controller for the multi-cycle MIPS core. It consumes the `opcode` and `alu_function` fields that `decoder_32` extracts from the instruction register. It steps the shared datapath through fetch, decode, execute, memory and writeback using per-state control strobes, and handshakes with the unified instruction/data memory. It also counts retired instructions and traps on unsupported encodings.

## Interface
- `COUNT_WIDTH`, 32, width of `retired_count`.
- `clock`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  6  from decoder, driven by the instruction register.
- `alu_function`  in  6  funct field from decoder.
- `alu_zero`  in  1  ALU result == 0.
- `mem_ready`  in  1  memory completes the current request this cycle.
- `mem_request`  out  1  memory access active.
- `mem_write`  out  1  access is a store.
- `iord`  out  1  address source: 0 = PC, 1 = ALUOut.
- `ir_load`  out  1  load the instruction register from memory data.
- `pc_write`  out  1  load PC.
- `pc_source`  out  2  PC source: 0 = ALU (PC+4), 1 = ALUOut (branch target), 2 = {PC[31:28], jump_target, 2'b00}, 3 = rs.
- `alu_src_a`  out  1  ALU operand A: 0 = PC, 1 = rs.
- `alu_src_b`  out  2  ALU operand B: 0 = rt, 1 = constant 4, 2 = extended immediate, 3 = sign-extended immediate << 2.
- `imm_zero_extend`  out  1  immediate extender mode: 1 = zero-extend, 0 = sign-extend.
- `alu_control`  out  4  ALU op: 0 add, 1 sub, 2 and, 3 or, 4 slt, 5 sll, 6 srl, 7 lui.
- `alu_out_load`  out  1  latch ALUOut.
- `reg_write`  out  1  register file write enable.
- `reg_dst`  out  2  destination register: 0 = rt, 1 = rd, 2 = $31.
- `mem_to_reg`  out  2  writeback data: 0 = ALUOut, 1 = MDR, 2 = PC.
- `illegal_instruction`  out  1  sticky trap flag.
- `retired_count`  out  COUNT_WIDTH  retired-instruction counter.

## Operation
Outputs not listed for a state are 0.

States and transitions:
- **FETCH**
  - Strobes: `mem_request`, `iord`=0, `alu_src_a`=0, `alu_src_b`=1, add.
  - Holds until `mem_ready`.
  - In the `mem_ready` cycle: `ir_load`=1, `pc_write`=1, `pc_source`=0. Next state DECODE.
- **DECODE**
  - Strobes: `alu_src_a`=0, `alu_src_b`=3, add, `alu_out_load`.
  - Next state by `opcode`:
    - 0x00 with funct 0x20/0x22/0x24/0x25/0x2A/0x00/0x02 → EXEC_R.
    - 0x00 with funct 0x08 → JUMP.
    - 0x08/0x0A/0x0C/0x0D/0x0F → EXEC_I.
    - 0x23/0x2B → MEM_ADDR.
    - 0x04/0x05 → BRANCH.
    - 0x02/0x03 → JUMP.
    - Anything else → TRAP.
- **EXEC_R**
  - Strobes: `alu_src_a`=1, `alu_src_b`=0, `alu_out_load`.
  - `alu_control` from funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt, 0x00 sll, 0x02 srl.
  - Next state WB_ALU.
- **EXEC_I**
  - Strobes: `alu_src_a`=1, `alu_src_b`=2, `alu_out_load`.
  - 0x08 → add; 0x0A → slt; 0x0C → and with zero-extend; 0x0D → or with zero-extend; 0x0F → lui.
  - Next state WB_ALU.
- **WB_ALU**
  - Strobes: `reg_write`, `mem_to_reg`=0, `reg_dst`=1 for R-type and 0 for I-type.
  - Retire. Next state FETCH.
- **MEM_ADDR**
  - Strobes: `alu_src_a`=1, `alu_src_b`=2, add, `alu_out_load`.
  - Next state MEM_READ (0x23) or MEM_WRITE (0x2B).
- **MEM_READ**
  - Strobes: `mem_request`, `iord`=1. The datapath latches MDR on `mem_ready`.
  - Holds until `mem_ready`, then WB_MEM.
- **WB_MEM**
  - Strobes: `reg_write`, `reg_dst`=0, `mem_to_reg`=1.
  - Retire. Next state FETCH.
- **MEM_WRITE**
  - Strobes: `mem_request`, `mem_write`, `iord`=1.
  - Holds until `mem_ready`, then retire and go to FETCH.
- **BRANCH**
  - Strobes: `alu_src_a`=1, `alu_src_b`=0, sub, `pc_source`=1.
  - `pc_write` = `alu_zero` for beq, `!alu_zero` for bne.
  - Retire. Next state FETCH.
- **JUMP**
  - Strobes: `pc_write`. `pc_source`=2 for j/jal, 3 for jr.
  - jal additionally: `reg_write`, `reg_dst`=2, `mem_to_reg`=2. PC already holds PC+4 at this point.
  - Retire. Next state FETCH.
- **TRAP**
  - `illegal_instruction`=1, all strobes 0. Exit only by reset.

Additional rules:
- `opcode` and `alu_function` are sampled combinationally in every state. The instruction register is stable from DECODE onward.
- Retire increments `retired_count` by 1 and wraps modulo 2^COUNT_WIDTH. An illegal instruction never retires.

## Timing
- Reset (asynchronous, `reset_n`=0): state ← FETCH, `retired_count` ← 0, `illegal_instruction` ← 0, all strobes 0.
  - Memory strobes are also forced to 0 while `reset_n` is low.
  - A reset mid-access abandons the request. FETCH reasserts `mem_request` in the first clock after release.
- Strobes are Moore outputs decoded from state. Exceptions:
  - `ir_load` and `pc_write` in FETCH depend on `mem_ready`.
  - `pc_write` in BRANCH depends on `alu_zero`.
- Memory handshake: `mem_request`, `mem_write` and `iord` stay constant while waiting. The access completes in the cycle `mem_ready`=1; the state advances at that clock edge.
- `mem_ready` asserted while `mem_request`=0 is ignored.
- Cycle counts with zero wait states:
  - R-type, I-type, load: 4 / 4 / 5.
  - Store, branch, jump: 4 / 3 / 3.
  - Each memory wait cycle adds 1.
- The `retired_count` update is visible in the cycle after the retiring state.

## Test plan
- Reset release with `mem_ready`=1, IR = add (opcode 0x00, funct 0x20): states FETCH, DECODE, EXEC_R, WB_ALU.
  - `reg_write`=1 with `reg_dst`=1 in cycle 4; `retired_count`=1.
- Load (opcode 0x23) with `mem_ready` low for 3 cycles in MEM_READ: `mem_request`=1, `iord`=1 held for 4 cycles.
  - Then WB_MEM with `mem_to_reg`=1; 8 cycles in total.
- beq (opcode 0x04) with `alu_zero`=1 → `pc_write`=1, `pc_source`=1. bne (opcode 0x05) with `alu_zero`=1 → `pc_write`=0. Both retire.
- jal (opcode 0x03): JUMP asserts `pc_source`=2, `reg_dst`=2, `mem_to_reg`=2, `reg_write`=1. jr (0x00/0x08): `pc_source`=3, `reg_write`=0.
- Opcode 0x3F: TRAP is entered and `illegal_instruction`=1 stays set for 20 cycles with `mem_request`=0.
  - `retired_count` unchanged; `reset_n` pulse clears the flag.
- `reset_n` asserted mid-MEM_WRITE: `mem_write` drops immediately (asynchronous). FETCH resumes, and a preset `retired_count` of 0xFFFFFFFF wraps to 0 after one retire.
